// File: rtl/dpic_mem_arbiter.sv
// rtl/dpic_mem_arbiter.sv - round-robin fetch/load-store arbiter onto a single memory port
module dpic_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_resp_data,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_req_wen,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_resp_data,
    output logic                  ls_resp_err,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  mem_we_en,
    output logic [ADDR_W-1:0]     mem_we_addr,
    output logic [DATA_W-1:0]     mem_we_data,
    output logic [DATA_W/8-1:0]   mem_we_mask
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [MASK_W-1:0] MASK_B = MASK_W'(8'h01);
    localparam logic [MASK_W-1:0] MASK_H = MASK_W'(8'h03);
    localparam logic [MASK_W-1:0] MASK_W4 = MASK_W'(8'h0F);
    localparam logic [MASK_W-1:0] MASK_D = MASK_W'(8'hFF);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_ls_q;
    logic                grant_ls_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                err_q;
    logic [DATA_W-1:0]   if_data_q;
    logic [DATA_W-1:0]   ls_data_q;

    logic pick_ls;
    logic accept;
    logic mask_ok;
    logic in_access;
    logic in_resp;

    // LS wins only when alone or when IF was served last
    assign pick_ls   = ls_req_valid & (~if_req_valid | ~last_ls_q);
    assign accept    = (if_req_valid & if_req_ready) | (ls_req_valid & ls_req_ready);
    assign mask_ok   = (wmask_q == MASK_B) | (wmask_q == MASK_H) |
                       (wmask_q == MASK_W4) | (wmask_q == MASK_D);
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    always_comb begin
        state_d      = state_q;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // gated by rst so that readies read 0 while reset is held
                if_req_ready = rst & ~pick_ls;
                ls_req_ready = rst & pick_ls;
                if (accept) state_d = ACCESS;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_ls_q  <= 1'b1;
            grant_ls_q <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err_q      <= 1'b0;
            if_data_q  <= '0;
            ls_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_ls_q  <= pick_ls;
                grant_ls_q <= pick_ls;
                addr_q     <= pick_ls ? ls_req_addr : if_req_addr;
                wen_q      <= pick_ls & ls_req_wen;
                wdata_q    <= pick_ls ? ls_req_wdata : '0;
                wmask_q    <= pick_ls ? ls_req_wmask : '0;
            end
            if (in_access) begin
                err_q <= wen_q & ~mask_ok;
                if (grant_ls_q) ls_data_q <= wen_q ? '0 : mem_rd_data;
                else            if_data_q <= mem_rd_data;
            end
        end
    end

    assign mem_rd_en   = in_access & ~wen_q;
    assign mem_rd_addr = mem_rd_en ? addr_q : '0;
    assign mem_we_en   = in_access & wen_q & mask_ok;
    assign mem_we_addr = mem_we_en ? addr_q : '0;
    assign mem_we_data = mem_we_en ? wdata_q : '0;
    assign mem_we_mask = mem_we_en ? wmask_q : '0;

    assign if_resp_valid = in_resp & ~grant_ls_q;
    assign ls_resp_valid = in_resp & grant_ls_q;
    assign ls_resp_err   = ls_resp_valid & err_q;
    assign if_resp_data  = if_data_q;
    assign ls_resp_data  = ls_data_q;
endmodule

// File: tb/tb_dpic_mem_arbiter.sv
// tb/tb_dpic_mem_arbiter.sv - directed table-driven bench for dpic_mem_arbiter
module tb_dpic_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_req_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid, ls_resp_err;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
    logic [7:0]  ls_req_wmask;
    logic        mem_rd_en, mem_we_en;
    logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
    logic [7:0]  mem_we_mask;
    logic [63:0] cur_rdata;

    always #5 clk = ~clk;

    assign mem_rd_data = mem_rd_en ? cur_rdata : 64'h0;

    dpic_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data),
        .mem_we_mask(mem_we_mask)
    );

    typedef struct {
        logic        is_ls;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic [63:0] exp_data;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_if, exp_ls;
    vec_t vecs[11];

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        cur_rdata = v.rdata;
        if (v.is_ls) begin
            ls_req_valid = 1'b1; ls_req_wen = v.wen; ls_req_addr = v.addr;
            ls_req_wdata = v.wdata; ls_req_wmask = v.wmask;
        end else begin
            if_req_valid = 1'b1; if_req_addr = v.addr;
        end
        #1;
        chk1($sformatf("v%0d_if_ready", idx), if_req_ready, ~v.is_ls);
        chk1($sformatf("v%0d_ls_ready", idx), ls_req_ready, v.is_ls);
        chk1($sformatf("v%0d_idle_rd_en", idx), mem_rd_en, 1'b0);
        @(posedge clk);
        #1;
        // inputs become don't-care after acceptance
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        if_req_addr = '1; ls_req_addr = '1; ls_req_wdata = '1;
        ls_req_wmask = 8'h55; ls_req_wen = ~v.wen;
        @(negedge clk);
        #1;
        chk1($sformatf("v%0d_acc_rd_en", idx), mem_rd_en, ~v.wen);
        chk64($sformatf("v%0d_acc_rd_addr", idx), mem_rd_addr, v.wen ? 64'h0 : v.addr);
        chk1($sformatf("v%0d_acc_we_en", idx), mem_we_en, v.exp_we);
        chk64($sformatf("v%0d_acc_we_addr", idx), mem_we_addr, v.exp_we ? v.addr : 64'h0);
        chk64($sformatf("v%0d_acc_we_data", idx), mem_we_data, v.exp_we ? v.wdata : 64'h0);
        chk64($sformatf("v%0d_acc_we_mask", idx), 64'(mem_we_mask), v.exp_we ? 64'(v.wmask) : 64'h0);
        chk1($sformatf("v%0d_acc_readies", idx), if_req_ready | ls_req_ready, 1'b0);
        chk1($sformatf("v%0d_acc_no_resp", idx), if_resp_valid | ls_resp_valid, 1'b0);
        @(negedge clk);
        #1;
        if (v.is_ls) exp_ls = v.exp_data;
        else         exp_if = v.exp_data;
        chk1($sformatf("v%0d_resp_if_valid", idx), if_resp_valid, ~v.is_ls);
        chk1($sformatf("v%0d_resp_ls_valid", idx), ls_resp_valid, v.is_ls);
        chk1($sformatf("v%0d_resp_err", idx), ls_resp_err, v.exp_err);
        chk64($sformatf("v%0d_resp_if_data", idx), if_resp_data, exp_if);
        chk64($sformatf("v%0d_resp_ls_data", idx), ls_resp_data, exp_ls);
        chk1($sformatf("v%0d_resp_mem_idle", idx), mem_rd_en | mem_we_en, 1'b0);
        @(negedge clk);
        #1;
        chk1($sformatf("v%0d_post_valid", idx), if_resp_valid | ls_resp_valid, 1'b0);
        chk64($sformatf("v%0d_post_if_data", idx), if_resp_data, exp_if);
        chk64($sformatf("v%0d_post_ls_data", idx), ls_resp_data, exp_ls);
    endtask

    initial begin
        int grants[8];
        int resp_port[8];
        int resp_cyc[8];
        int ng;
        int nr;

        //            is_ls wen  addr                 wdata                  mask   rdata                  exp_data               we    err
        vecs[0]  = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 64'h0000_0013_0000_0297, 64'h0000_0013_0000_0297, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0100, 64'h1122_3344_5566_7788, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0110, 64'h0102_0304_0506_0708, 8'h05, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 8'h00, 64'h0000_0000_00A0_0093, 64'h0000_0000_00A0_0093, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0200, 64'h0000_0000_0000_00EE, 8'h01, 64'h0, 64'h0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0208, 64'h0, 8'h00, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0202, 64'h0000_0000_0000_BEEF, 8'h03, 64'h0, 64'h0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0300, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 64'h0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0308, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 64'h0000_0000_8000_0310, 64'h1234_5678_9ABC_DEF0, 8'h80, 64'h0, 64'h0, 1'b0, 1'b1};

        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h8000_0100;
        ls_req_wdata = 64'h1; ls_req_wmask = 8'hFF;
        cur_rdata = 64'h0;
        #3;
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_ls_ready", ls_req_ready, 1'b0);
        chk1("rst_resp_valid", if_resp_valid | ls_resp_valid | ls_resp_err, 1'b0);
        chk1("rst_mem_en", mem_rd_en | mem_we_en, 1'b0);
        chk64("rst_if_data", if_resp_data, 64'h0);
        chk64("rst_ls_data", ls_resp_data, 64'h0);
        chk64("rst_mem_addr", mem_rd_addr | mem_we_addr | mem_we_data, 64'h0);
        @(posedge clk);

        // both requesters valid continuously from reset release: IF, LS, IF, LS
        @(negedge clk);
        rst = 1'b1;
        ls_req_wen = 1'b0; ls_req_addr = 64'h8000_0400;
        cur_rdata = 64'h0BAD_F00D_1234_5678;
        ng = 0; nr = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (if_req_valid && if_req_ready && ng < 8) begin grants[ng] = 0; ng++; end
            else if (ls_req_valid && ls_req_ready && ng < 8) begin grants[ng] = 1; ng++; end
            chk1($sformatf("rr_overlap_c%0d", k), if_resp_valid & ls_resp_valid, 1'b0);
            if ((if_resp_valid || ls_resp_valid) && nr < 8) begin
                resp_port[nr] = ls_resp_valid ? 1 : 0;
                resp_cyc[nr] = k;
                nr++;
            end
            @(negedge clk);
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        chk64("rr_grant_count", 64'(ng), 64'd4);
        chk64("rr_resp_count", 64'(nr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk64($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
            if (i < nr) begin
                chk64($sformatf("rr_resp_port%0d", i), 64'(resp_port[i]), 64'(i % 2));
                chk64($sformatf("rr_resp_cyc%0d", i), 64'(resp_cyc[i]), 64'(2 + 3 * i));
            end
        end
        exp_if = 64'h0BAD_F00D_1234_5678;
        exp_ls = 64'h0BAD_F00D_1234_5678;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // asynchronous reset while a store is in ACCESS
        @(negedge clk);
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h8000_0500;
        ls_req_wdata = 64'hCAFE_0000_0000_BABE; ls_req_wmask = 8'hFF;
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk1("arst_we_before", mem_we_en, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("arst_we_after", mem_we_en, 1'b0);
        chk64("arst_we_addr", mem_we_addr, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_if = 64'h0;
        exp_ls = 64'h0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1($sformatf("arst_no_resp_c%0d", k), if_resp_valid | ls_resp_valid, 1'b0);
            chk1($sformatf("arst_no_we_c%0d", k), mem_we_en, 1'b0);
            @(negedge clk);
        end
        chk64("arst_if_data_clr", if_resp_data, 64'h0);
        run_vec(20, vecs[0]);
        run_vec(21, vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
